// File: rtl/write_back_unit_pkg.sv
// write_back_unit_pkg
//   Shared constants and types for the Risky write-back stage.
//   DATA_SIZE / GPR_SIZE : default register data width and register index width
//   WB_QUEUE_DEPTH       : entries in the write queue (two sources, one write port)
//   wb_state_t           : load-tracking FSM states
package write_back_unit_pkg;

    localparam int DATA_SIZE      = 16;
    localparam int GPR_SIZE       = 3;
    localparam int WB_QUEUE_DEPTH = 2;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_LOAD_WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/write_back_unit_wb_queue.sv
// write_back_unit_wb_queue
//   Two-entry FIFO of {addr, data} pairs feeding the register-file write port.
//   clock, reset            : rising-edge clock, asynchronous active-high reset
//   i_push_a / i_push_b     : up to two pushes per cycle; a is enqueued ahead of b
//   i_pop                   : remove the head entry
//   o_count                 : current occupancy (0..2)
//   o_valid[1:0]            : per-entry valid, entry 0 is the head
//   o_head_* / o_tail_*     : oldest and newest entries, used for write-back and bypass
module write_back_unit_wb_queue
    import write_back_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_SIZE,
    parameter int ADDR_WIDTH = GPR_SIZE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_push_a,
    input  logic [ADDR_WIDTH-1:0] i_push_a_addr,
    input  logic [DATA_WIDTH-1:0] i_push_a_data,
    input  logic                  i_push_b,
    input  logic [ADDR_WIDTH-1:0] i_push_b_addr,
    input  logic [DATA_WIDTH-1:0] i_push_b_data,
    input  logic                  i_pop,
    output logic [1:0]            o_count,
    output logic [1:0]            o_valid,
    output logic [ADDR_WIDTH-1:0] o_head_addr,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic [ADDR_WIDTH-1:0] o_tail_addr,
    output logic [DATA_WIDTH-1:0] o_tail_data
);

    localparam logic [1:0] FULL = 2'(WB_QUEUE_DEPTH);

    logic [ADDR_WIDTH-1:0] r_addr [WB_QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] r_data [WB_QUEUE_DEPTH];
    logic [1:0]            r_count;

    logic [ADDR_WIDTH-1:0] w_addr [WB_QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] w_data [WB_QUEUE_DEPTH];
    logic [1:0]            w_count;

    // Pop shifts entry 1 down first, then pushes append behind whatever remains.
    always_comb begin
        w_addr  = r_addr;
        w_data  = r_data;
        w_count = r_count;
        if (i_pop && (r_count != 2'd0)) begin
            w_addr[0] = r_addr[1];
            w_data[0] = r_data[1];
            w_count   = r_count - 2'd1;
        end
        if (i_push_a && (w_count < FULL)) begin
            w_addr[w_count[0]] = i_push_a_addr;
            w_data[w_count[0]] = i_push_a_data;
            w_count            = w_count + 2'd1;
        end
        if (i_push_b && (w_count < FULL)) begin
            w_addr[w_count[0]] = i_push_b_addr;
            w_data[w_count[0]] = i_push_b_data;
            w_count            = w_count + 2'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            for (int i = 0; i < WB_QUEUE_DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_count <= w_count;
            r_addr  <= w_addr;
            r_data  <= w_data;
        end
    end

    assign o_count     = r_count;
    assign o_valid     = {r_count == FULL, r_count != 2'd0};
    assign o_head_addr = r_addr[0];
    assign o_head_data = r_data[0];
    assign o_tail_addr = (r_count == FULL) ? r_addr[1] : r_addr[0];
    assign o_tail_data = (r_count == FULL) ? r_data[1] : r_data[0];

endmodule

// File: rtl/write_back_unit.sv
// write_back_unit
//   Final pipeline stage: owns the register-file write port, merging ALU results
//   and asynchronous load returns through a two-entry write queue.
//   clock, reset                 : rising-edge clock, asynchronous active-high reset
//   halt                         : global freeze (load returns still captured)
//   alu_valid/alu_dest/alu_data  : ALU result from execute
//   load_issue/load_dest         : a LOAD was issued this cycle
//   mem_ready/mem_data           : load data return (single-cycle pulse)
//   read_address0/1              : operand-read addresses for bypass and hazard check
//   write_enable/address/data    : registered register-file write port
//   bypass_hit0/1, bypass_data0/1: newer-than-regfile value for each read address
//   hazard_stall                 : upstream must hold its outputs
//   load_error                   : one-cycle pulse when a load times out
//   debug_state                  : current load-tracking FSM state
//
// Handshake: an ALU result is taken only in a cycle where alu_valid=1,
// hazard_stall=0 and halt=0; otherwise upstream keeps presenting it.
// mem_ready is never back-pressured.
module write_back_unit
    import write_back_unit_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_SIZE,
    parameter int ADDR_WIDTH   = GPR_SIZE,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  halt,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_dest,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  load_issue,
    input  logic [ADDR_WIDTH-1:0] load_dest,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [ADDR_WIDTH-1:0] read_address0,
    input  logic [ADDR_WIDTH-1:0] read_address1,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  bypass_hit0,
    output logic [DATA_WIDTH-1:0] bypass_data0,
    output logic                  bypass_hit1,
    output logic [DATA_WIDTH-1:0] bypass_data1,
    output logic                  hazard_stall,
    output logic                  load_error,
    output wb_state_t             debug_state
);

    localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(LOAD_TIMEOUT - 1);

    wb_state_t             r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_pending_dest, w_pending_dest_next;
    logic [CNT_W-1:0]      r_timeout_count, w_timeout_count_next;
    logic                  r_load_error, w_load_error_next;

    logic                  r_write_enable, w_write_enable_next;
    logic [ADDR_WIDTH-1:0] r_write_address, w_write_address_next;
    logic [DATA_WIDTH-1:0] r_write_data, w_write_data_next;

    logic                  w_load_valid;
    logic                  w_alu_accept;
    logic                  w_hazard_stall;

    logic                  w_push_a, w_push_b, w_pop;
    logic [ADDR_WIDTH-1:0] w_push_a_addr;
    logic [DATA_WIDTH-1:0] w_push_a_data;
    logic [1:0]            w_q_count;
    logic [1:0]            w_q_valid;
    logic [ADDR_WIDTH-1:0] w_q_head_addr, w_q_tail_addr;
    logic [DATA_WIDTH-1:0] w_q_head_data, w_q_tail_data;
    logic [DATA_WIDTH:0]   w_bypass0, w_bypass1;

    write_back_unit_wb_queue #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_queue (
        .clock        (clock),
        .reset        (reset),
        .i_push_a     (w_push_a),
        .i_push_a_addr(w_push_a_addr),
        .i_push_a_data(w_push_a_data),
        .i_push_b     (w_push_b),
        .i_push_b_addr(alu_dest),
        .i_push_b_data(alu_data),
        .i_pop        (w_pop),
        .o_count      (w_q_count),
        .o_valid      (w_q_valid),
        .o_head_addr  (w_q_head_addr),
        .o_head_data  (w_q_head_data),
        .o_tail_addr  (w_q_tail_addr),
        .o_tail_data  (w_q_tail_data)
    );

    // A load return counts only while a load is outstanding, halted or not.
    assign w_load_valid = (r_state == WB_LOAD_WAIT) && mem_ready;

    assign w_hazard_stall = (w_q_count == 2'(WB_QUEUE_DEPTH))
                          | ((r_state == WB_LOAD_WAIT)
                             & ((read_address0 == r_pending_dest)
                                | (read_address1 == r_pending_dest)
                                | load_issue));

    assign w_alu_accept = alu_valid && !w_hazard_stall && !halt;

    // Load-tracking FSM
    always_comb begin
        w_state_next         = r_state;
        w_pending_dest_next  = r_pending_dest;
        w_timeout_count_next = r_timeout_count;
        w_load_error_next    = 1'b0;
        case (r_state)
            WB_IDLE: begin
                if (load_issue && !halt) begin
                    w_state_next         = WB_LOAD_WAIT;
                    w_pending_dest_next  = load_dest;
                    w_timeout_count_next = '0;
                end
            end
            WB_LOAD_WAIT: begin
                if (mem_ready) begin
                    w_state_next = WB_IDLE;
                end else if (!halt) begin
                    if (r_timeout_count == LAST_WAIT) begin
                        w_state_next      = WB_IDLE;
                        w_load_error_next = 1'b1;
                    end else begin
                        w_timeout_count_next = r_timeout_count + 1'b1;
                    end
                end
            end
            default: w_state_next = WB_IDLE;
        endcase
    end

    // Write-port arbitration: queue head > load result > ALU result.
    // Losers are queued load-first so writes retire in arrival order.
    always_comb begin
        w_write_enable_next  = 1'b0;
        w_write_address_next = r_write_address;
        w_write_data_next    = r_write_data;
        w_pop                = 1'b0;
        w_push_a             = 1'b0;
        w_push_a_addr        = r_pending_dest;
        w_push_a_data        = mem_data;
        w_push_b             = 1'b0;
        if (halt) begin
            w_push_a = w_load_valid;
        end else if (w_q_count != 2'd0) begin
            w_write_enable_next  = 1'b1;
            w_write_address_next = w_q_head_addr;
            w_write_data_next    = w_q_head_data;
            w_pop                = 1'b1;
            w_push_a             = w_load_valid;
            w_push_b             = w_alu_accept;
        end else if (w_load_valid) begin
            w_write_enable_next  = 1'b1;
            w_write_address_next = r_pending_dest;
            w_write_data_next    = mem_data;
            w_push_a             = w_alu_accept;
            w_push_a_addr        = alu_dest;
            w_push_a_data        = alu_data;
        end else if (w_alu_accept) begin
            w_write_enable_next  = 1'b1;
            w_write_address_next = alu_dest;
            w_write_data_next    = alu_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= WB_IDLE;
            r_pending_dest  <= '0;
            r_timeout_count <= '0;
            r_load_error    <= 1'b0;
            r_write_enable  <= 1'b0;
            r_write_address <= '0;
            r_write_data    <= '0;
        end else begin
            r_state         <= w_state_next;
            r_pending_dest  <= w_pending_dest_next;
            r_timeout_count <= w_timeout_count_next;
            r_load_error    <= w_load_error_next;
            r_write_enable  <= w_write_enable_next;
            r_write_address <= w_write_address_next;
            r_write_data    <= w_write_data_next;
        end
    end

    // Bypass: queue tail is newest, then the head (only distinct when two
    // entries are held), then the value on the write port.
    assign w_bypass0 = (w_q_valid[0] && (read_address0 == w_q_tail_addr)) ? {1'b1, w_q_tail_data} :
                       (w_q_valid[1] && (read_address0 == w_q_head_addr)) ? {1'b1, w_q_head_data} :
                       (r_write_enable && (read_address0 == r_write_address)) ? {1'b1, r_write_data} :
                       '0;
    assign w_bypass1 = (w_q_valid[0] && (read_address1 == w_q_tail_addr)) ? {1'b1, w_q_tail_data} :
                       (w_q_valid[1] && (read_address1 == w_q_head_addr)) ? {1'b1, w_q_head_data} :
                       (r_write_enable && (read_address1 == r_write_address)) ? {1'b1, r_write_data} :
                       '0;

    assign bypass_hit0   = w_bypass0[DATA_WIDTH];
    assign bypass_data0  = w_bypass0[DATA_WIDTH-1:0];
    assign bypass_hit1   = w_bypass1[DATA_WIDTH];
    assign bypass_data1  = w_bypass1[DATA_WIDTH-1:0];
    assign hazard_stall  = w_hazard_stall;
    assign load_error    = r_load_error;
    assign write_enable  = r_write_enable;
    assign write_address = r_write_address;
    assign write_data    = r_write_data;
    assign debug_state   = r_state;

endmodule

// File: tb/tb_write_back_unit.sv
`timescale 1ns/1ps
module tb_write_back_unit;
    import write_back_unit_pkg::*;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int T  = 20;
    localparam int EW = AW + DW;

    logic          clock = 1'b0;
    logic          reset, halt, alu_valid, load_issue, mem_ready;
    logic [AW-1:0] alu_dest, load_dest, read_address0, read_address1;
    logic [DW-1:0] alu_data, mem_data;
    logic          write_enable, bypass_hit0, bypass_hit1, hazard_stall, load_error;
    logic [AW-1:0] write_address;
    logic [DW-1:0] write_data, bypass_data0, bypass_data1;
    wb_state_t     debug_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: items accepted but not yet on the write port, in order.
    logic [EW-1:0] mq[$];
    logic          m_port_valid;
    logic [EW-1:0] m_port;
    logic          m_pend;
    logic [AW-1:0] m_pdest;
    int            m_wait;
    logic          m_err;
    // expected / sampled combinational outputs of the last ticked cycle
    logic          e_stall, e_hit0, e_hit1, s_stall, s_hit0, s_hit1;
    logic [DW-1:0] e_bp0, e_bp1, s_bp0, s_bp1;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];

    write_back_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOAD_TIMEOUT(T)) dut (
        .clock(clock), .reset(reset), .halt(halt),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
        .load_issue(load_issue), .load_dest(load_dest),
        .mem_ready(mem_ready), .mem_data(mem_data),
        .read_address0(read_address0), .read_address1(read_address1),
        .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
        .bypass_hit0(bypass_hit0), .bypass_data0(bypass_data0),
        .bypass_hit1(bypass_hit1), .bypass_data1(bypass_data1),
        .hazard_stall(hazard_stall), .load_error(load_error), .debug_state(debug_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic drive_idle();
        halt = 0; alu_valid = 0; alu_dest = '0; alu_data = '0;
        load_issue = 0; load_dest = '0; mem_ready = 0; mem_data = '0;
        read_address0 = '0; read_address1 = '0;
    endtask

    task automatic model_clear();
        mq.delete();
        m_port_valid = 0; m_port = '0; m_pend = 0; m_pdest = '0; m_wait = 0; m_err = 0;
    endtask

    task automatic apply_reset();
        reset = 1;
        drive_idle();
        @(posedge clock); #1;
        @(negedge clock); reset = 0;
        @(posedge clock); #1;
        model_clear();
    endtask

    // newest pending value for a register, if any
    task automatic lookup(input logic [AW-1:0] ra, output logic hit, output logic [DW-1:0] d);
        hit = 0; d = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!hit && mq[i][EW-1:DW] == ra) begin hit = 1; d = mq[i][DW-1:0]; end
        end
        if (!hit && m_port_valid && m_port[EW-1:DW] == ra) begin hit = 1; d = m_port[DW-1:0]; end
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Entered at posedge+1 with inputs driven; returns at the next posedge+1.
    task automatic tick();
        logic load_ret, alu_acc, tmo;
        @(negedge clock);
        e_stall = (mq.size() == 2) || (m_pend && (read_address0 == m_pdest ||
                  read_address1 == m_pdest || load_issue));
        lookup(read_address0, e_hit0, e_bp0);
        lookup(read_address1, e_hit1, e_bp1);
        s_stall = hazard_stall; s_hit0 = bypass_hit0; s_bp0 = bypass_data0;
        s_hit1 = bypass_hit1; s_bp1 = bypass_data1;
        load_ret = m_pend && mem_ready;
        alu_acc  = alu_valid && !e_stall && !halt;
        tmo      = m_pend && !mem_ready && !halt && (m_wait + 1 == T);
        if (load_ret) mq.push_back({m_pdest, mem_data});
        if (alu_acc)  mq.push_back({alu_dest, alu_data});
        if (!halt && mq.size() > 0) begin
            m_port = mq.pop_front(); m_port_valid = 1;
        end else begin
            m_port_valid = 0;
        end
        m_err = tmo;
        if (m_pend) begin
            if (load_ret || tmo) m_pend = 0;
            else if (!halt) m_wait++;
        end else if (load_issue && !halt) begin
            m_pend = 1; m_pdest = load_dest; m_wait = 0;
        end
        @(posedge clock); #1;
    endtask

    task automatic collect();
        if (write_enable === 1'b1) got_q.push_back({write_address, write_data});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1; drive_idle();
        #7;
        n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", write_enable); end
        n_checks++; if (write_address !== '0) begin n_fail++; $display("FAIL reset_waddr: got %h want 0", write_address); end
        n_checks++; if (write_data !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", write_data); end
        n_checks++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL reset_load_error: got %b want 0", load_error); end
        n_checks++; if (debug_state !== WB_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", debug_state); end
        n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", hazard_stall); end
        n_checks++; if (bypass_hit0 !== 1'b0) begin n_fail++; $display("FAIL reset_hit0: got %b want 0", bypass_hit0); end
        apply_reset();
    endtask

    task automatic test_alu_single();
        alu_valid = 1; alu_dest = 3'd3; alu_data = 16'h1234;
        tick();
        alu_valid = 0;
        n_checks++; if ({write_enable, write_address, write_data} !== {1'b1, 3'd3, 16'h1234}) begin
            n_fail++; $display("FAIL alu_write: got we=%b a=%0d d=%h want 1/3/1234", write_enable, write_address, write_data); end
        tick();
        n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL alu_after: got we=%b want 0", write_enable); end
    endtask

    task automatic test_load_collision();
        apply_reset();
        load_issue = 1; load_dest = 3'd5; tick(); load_issue = 0;
        repeat (3) tick();
        mem_ready = 1; mem_data = 16'hBEEF; alu_valid = 1; alu_dest = 3'd2; alu_data = 16'h0007;
        tick();
        mem_ready = 0; alu_valid = 0;
        n_checks++; if ({write_enable, write_address, write_data} !== {1'b1, 3'd5, 16'hBEEF}) begin
            n_fail++; $display("FAIL collision_load: got we=%b a=%0d d=%h want 1/5/beef", write_enable, write_address, write_data); end
        tick();
        n_checks++; if ({write_enable, write_address, write_data} !== {1'b1, 3'd2, 16'h0007}) begin
            n_fail++; $display("FAIL collision_alu: got we=%b a=%0d d=%h want 1/2/0007", write_enable, write_address, write_data); end
        tick();
        n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL collision_idle: got we=%b want 0", write_enable); end
    endtask

    task automatic test_hazard_bypass();
        apply_reset();
        read_address0 = 3'd4; read_address1 = 3'd1;
        load_issue = 1; load_dest = 3'd4; tick(); load_issue = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (s_stall !== 1'b1) begin n_fail++; $display("FAIL hazard_wait%0d: got %b want 1", i, s_stall); end
        end
        mem_ready = 1; mem_data = 16'hA5A5;
        tick();
        mem_ready = 0;
        n_checks++; if (s_stall !== 1'b1) begin n_fail++; $display("FAIL hazard_ready_cycle: got %b want 1", s_stall); end
        n_checks++; if ({write_enable, write_address, write_data} !== {1'b1, 3'd4, 16'hA5A5}) begin
            n_fail++; $display("FAIL hazard_write: got we=%b a=%0d d=%h want 1/4/a5a5", write_enable, write_address, write_data); end
        tick();
        n_checks++; if (s_stall !== 1'b0) begin n_fail++; $display("FAIL hazard_release: got %b want 0", s_stall); end
        n_checks++; if ({s_hit0, s_bp0} !== {1'b1, 16'hA5A5}) begin n_fail++; $display("FAIL bypass0_hit: got %b/%h want 1/a5a5", s_hit0, s_bp0); end
        n_checks++; if ({s_hit1, s_bp1} !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL bypass1_miss: got %b/%h want 0/0000", s_hit1, s_bp1); end
        tick();
        n_checks++; if (s_hit0 !== 1'b0) begin n_fail++; $display("FAIL bypass0_expire: got %b want 0", s_hit0); end
        read_address0 = '0; read_address1 = '0;
    endtask

    task automatic test_queue_full();
        apply_reset();
        got_q.delete(); exp_q.delete();
        exp_q.push_back({3'd1, 16'h1111}); exp_q.push_back({3'd2, 16'h2222});
        exp_q.push_back({3'd3, 16'h3333}); exp_q.push_back({3'd4, 16'h4444});
        exp_q.push_back({3'd5, 16'h5555}); exp_q.push_back({3'd6, 16'h6666});
        load_issue = 1; load_dest = 3'd1; tick(); collect(); load_issue = 0;
        mem_ready = 1; mem_data = 16'h1111; alu_valid = 1; alu_dest = 3'd2; alu_data = 16'h2222;
        tick(); collect();
        mem_ready = 0; load_issue = 1; load_dest = 3'd4; alu_dest = 3'd3; alu_data = 16'h3333;
        tick(); collect();
        load_issue = 0; mem_ready = 1; mem_data = 16'h4444; alu_dest = 3'd5; alu_data = 16'h5555;
        tick(); collect();
        mem_ready = 0; alu_dest = 3'd6; alu_data = 16'h6666;
        tick(); collect();
        n_checks++; if (s_stall !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %b want 1", s_stall); end
        tick(); collect();
        n_checks++; if (s_stall !== 1'b0) begin n_fail++; $display("FAIL full_release: got %b want 0", s_stall); end
        alu_valid = 0;
        repeat (3) begin tick(); collect(); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL full_count: got %0d writes want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_order%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_timeout();
        int k;
        apply_reset();
        load_issue = 1; load_dest = 3'd6; tick(); load_issue = 0;
        k = 0;
        while (load_error !== 1'b1 && k < T + 10) begin tick(); k++; end
        n_checks++; if (k != T) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles want %0d", k, T); end
        n_checks++; if (debug_state !== WB_IDLE) begin n_fail++; $display("FAIL timeout_state: got %0d want IDLE", debug_state); end
        tick();
        n_checks++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got %b want 0", load_error); end
        mem_ready = 1; mem_data = 16'hDEAD; tick(); mem_ready = 0;
        n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL late_ready: got we=%b want 0", write_enable); end
    endtask

    task automatic test_halt();
        apply_reset();
        load_issue = 1; load_dest = 3'd1; tick(); load_issue = 0;
        mem_ready = 1; mem_data = 16'h0A0A; alu_valid = 1; alu_dest = 3'd2; alu_data = 16'h0B0B;
        tick();
        mem_ready = 0; load_issue = 1; load_dest = 3'd3; alu_dest = 3'd4; alu_data = 16'h0C0C;
        tick();
        load_issue = 0; alu_valid = 0; halt = 1; mem_ready = 1; mem_data = 16'h0D0D;
        tick();
        n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL halt_we0: got %b want 0", write_enable); end
        mem_ready = 0; alu_valid = 1; alu_dest = 3'd5; alu_data = 16'h0E0E;
        tick();
        n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL halt_we1: got %b want 0", write_enable); end
        halt = 0; alu_valid = 0;
        tick();
        n_checks++; if ({write_enable, write_address, write_data} !== {1'b1, 3'd4, 16'h0C0C}) begin
            n_fail++; $display("FAIL halt_drain0: got we=%b a=%0d d=%h want 1/4/0c0c", write_enable, write_address, write_data); end
        tick();
        n_checks++; if ({write_enable, write_address, write_data} !== {1'b1, 3'd3, 16'h0D0D}) begin
            n_fail++; $display("FAIL halt_drain1: got we=%b a=%0d d=%h want 1/3/0d0d", write_enable, write_address, write_data); end
        tick();
        n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL halt_drain_end: got %b want 0", write_enable); end
    endtask

    task automatic test_reset_mid_load();
        int pulses;
        apply_reset();
        read_address0 = 3'd3;
        alu_valid = 1; alu_dest = 3'd7; alu_data = 16'h7777;
        load_issue = 1; load_dest = 3'd3; tick(); load_issue = 0; alu_valid = 0;
        #2 reset = 1;
        #1;
        n_checks++; if (debug_state !== WB_IDLE) begin n_fail++; $display("FAIL midreset_state: got %0d want IDLE", debug_state); end
        n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL midreset_we: got %b want 0", write_enable); end
        n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL midreset_stall: got %b want 0", hazard_stall); end
        @(negedge clock); reset = 0;
        @(posedge clock); #1;
        model_clear();
        mem_ready = 1; mem_data = 16'hFFFF; tick(); mem_ready = 0;
        n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL midreset_late_ready: got we=%b want 0", write_enable); end
        pulses = 0;
        repeat (T + 2) begin tick(); if (load_error === 1'b1) pulses++; end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL midreset_no_error: got %0d pulses want 0", pulses); end
        read_address0 = '0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            halt       = ($urandom_range(0, 9) == 0);
            alu_valid  = $urandom_range(0, 1);
            alu_dest   = AW'($urandom_range(0, 7));
            alu_data   = DW'($urandom);
            load_issue = ($urandom_range(0, 4) == 0);
            load_dest  = AW'($urandom_range(0, 7));
            mem_ready  = m_pend ? ($urandom_range(0, (c < 800) ? 3 : 40) == 0)
                                : ($urandom_range(0, 15) == 0);
            if (halt && mq.size() >= 2) mem_ready = 0;
            mem_data      = DW'($urandom);
            read_address0 = AW'($urandom_range(0, 7));
            read_address1 = AW'($urandom_range(0, 7));
            tick();
            n_checks++; if (write_enable !== m_port_valid) begin n_fail++; $display("FAIL rnd_we c=%0d: got %b want %b", c, write_enable, m_port_valid); end
            if (m_port_valid) begin
                n_checks++; if ({write_address, write_data} !== m_port) begin n_fail++; $display("FAIL rnd_wdata c=%0d: got %h want %h", c, {write_address, write_data}, m_port); end
            end
            n_checks++; if (load_error !== m_err) begin n_fail++; $display("FAIL rnd_load_error c=%0d: got %b want %b", c, load_error, m_err); end
            n_checks++; if (s_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall c=%0d: got %b want %b", c, s_stall, e_stall); end
            n_checks++; if ({s_hit0, s_bp0} !== {e_hit0, e_bp0}) begin n_fail++; $display("FAIL rnd_bypass0 c=%0d: got %b/%h want %b/%h", c, s_hit0, s_bp0, e_hit0, e_bp0); end
            n_checks++; if ({s_hit1, s_bp1} !== {e_hit1, e_bp1}) begin n_fail++; $display("FAIL rnd_bypass1 c=%0d: got %b/%h want %b/%h", c, s_hit1, s_bp1, e_hit1, e_bp1); end
        end
        drive_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_clear();
        test_reset();
        test_alu_single();
        test_load_collision();
        test_hazard_bypass();
        test_queue_full();
        test_timeout();
        test_halt();
        test_reset_mid_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
